// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: elastic pipelined add/sub, one carry-lookahead segment resolved per stage.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;
    logic [STAGES-1:0] vr, cr, zr, adv, nc, nz;
    logic [STAGES-1:0][WIDTH-1:0] ar, br, sr, na, nb, ns;
    logic [STAGES:0] vx, cx, zx;
    logic [STAGES:0][WIDTH-1:0] ax, bx, sx;
    logic [WIDTH-1:0] ta, tb, ts;
    logic c, t, p, nm, cm;
    // index 0 is the raw input beat, index k+1 is the register of stage k
    assign vx = {vr, in_valid};
    assign cx = {cr, cin ^ op};
    assign zx = {zr, 1'b1};
    assign ax = {ar, a};
    assign bx = {br, op ? ~b : b};
    assign sx = {sr, {WIDTH{1'b0}}};
    always_comb begin
        adv = '0;
        na = '0;
        nb = '0;
        ns = '0;
        nc = '0;
        nz = '0;
        ta = '0;
        tb = '0;
        ts = '0;
        c = 1'b0;
        t = 1'b0;
        p = 1'b0;
        nm = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            t = out_ready;
            for (int j = k; j < STAGES; j++) t = t | !vr[j];
            adv[k] = t;
            ta = ax[k];
            tb = bx[k];
            ts = sx[k];
            c = cx[k];
            // kill/generate sets the carry, propagate passes the one from below
            for (int j = 0; j < SEG; j++) begin
                p = ta[k*SEG+j] ^ tb[k*SEG+j];
                nm = c;
                ts[k*SEG+j] = p ^ c;
                c = p ? c : ta[k*SEG+j];
            end
            na[k] = ta;
            nb[k] = tb;
            ns[k] = ts;
            nc[k] = c;
            nz[k] = zx[k] && (ts[k*SEG +: SEG] == '0);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vr <= '0;
            ar <= '0;
            br <= '0;
            sr <= '0;
            cr <= '0;
            zr <= '0;
            cm <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vr[k] <= vx[k];
                    if (vx[k]) begin
                        ar[k] <= na[k];
                        br[k] <= nb[k];
                        sr[k] <= ns[k];
                        cr[k] <= nc[k];
                        zr[k] <= nz[k];
                    end
                end
            end
            if (adv[STAGES-1] && vx[STAGES-1]) cm <= nm;
        end
    end
    assign in_ready  = adv[0] & ~rst;
    assign out_valid = vr[STAGES-1];
    assign sum       = sr[STAGES-1];
    assign cout      = cr[STAGES-1];
    assign zero      = zr[STAGES-1];
    assign ovf       = cm ^ cr[STAGES-1];
endmodule
